key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input-side counterpart of the display scan/decoder path: converts raw, bouncy push-button levels (left, right, up, down, apply) into clean single-cycle command pulses for the select/adjust logic.
- Per-key 2-flop synchroniser and debouncer, followed by a one-key-at-a-time press FSM.
- Up/down auto-repeat while held; left/right/apply fire once per press.
- Runs on the system clock CP, between the board pins and select_control.

Parameters:
DEBOUNCE_CYCLES, 2000000, consecutive stable CP cycles required to accept a level change (20 ms at 100 MHz); must be >= 2
REPEAT_DELAY, 50000000, CP cycles from first up/down pulse to first repeat pulse (500 ms)
REPEAT_PERIOD, 15000000, CP cycles between subsequent repeat pulses (150 ms)

Ports:
CP  input  1  system clock, 100 MHz; sole clock
_CR  input  1  asynchronous active-low reset
key_raw  input  5  raw active-high buttons; bit4 apply, bit3 up, bit2 down, bit1 left, bit0 right
apply_p  output  1  one-CP pulse per accepted apply press
up_p  output  1  one-CP pulse per up press or repeat
down_p  output  1  one-CP pulse per down press or repeat
left_p  output  1  one-CP pulse per accepted left press
right_p  output  1  one-CP pulse per accepted right press
busy  output  1  high while a key is captured (FSM not IDLE)
key_db  output  5  debounced key levels, same bit order as key_raw

Behaviour:
- Reset (_CR low, asynchronous):
  - All pulses, busy and key_db go to 0.
  - Synchronisers, counters and the previous-level register clear.
  - FSM enters IDLE.
- Synchroniser: two flops per bit; the synced value lags key_raw by 2 CP cycles.
- Debounce, per bit:
  - The counter increments while synced != key_db and clears to 0 whenever synced == key_db.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, key_db toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Edge detect: rise = key_db & ~key_db_prev, where key_db_prev is key_db registered one cycle.
- FSM states:
  - IDLE:
    - If any rise bit is set, pick one by priority apply > up > down > left > right.
    - Register a pulse for the chosen key (visible the next cycle), capture the key, clear the timer, go to HOLD.
    - Rises of other keys in the same cycle are discarded.
  - HOLD:
    - If the captured key's key_db = 0, go to IDLE.
    - Else, if the captured key is up/down, the timer increments; at REPEAT_DELAY-1 emit a pulse, clear the timer, go to REPEAT.
    - left/right/apply stay in HOLD until release.
  - REPEAT:
    - If the captured key is released, go to IDLE.
    - Else the timer increments; at REPEAT_PERIOD-1 emit a pulse and clear the timer.
- Rises of non-captured keys during HOLD/REPEAT are ignored permanently.
  - A key still held when the FSM returns to IDLE does not fire until it is released and re-pressed.
- Release has priority over a repeat pulse due in the same cycle: no pulse is emitted.
- Outputs:
  - All pulse outputs are registered.
  - At most one pulse output is high in any cycle.
  - busy = (state != IDLE), registered together with the state.
- Latency: key_raw rising at edge N (stable thereafter) → key_db high at edge N+1+DEBOUNCE_CYCLES → pulse high for exactly one cycle at edge N+3+DEBOUNCE_CYCLES.
- Reset mid-hold:
  - FSM returns to IDLE and key_db clears.
  - If the key is still held after reset deasserts, it re-debounces and fires one fresh pulse.
- Timer width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); no wrap is possible because the timer clears at its terminal count.

Test Plan:
- Single press (DEBOUNCE_CYCLES=4): hold key_raw[1] high 30 cycles, then release → exactly one left_p pulse, 7 cycles after the input edge; busy high from the pulse cycle until 1 cycle after key_db[1] falls.
- Bounce rejection (DEBOUNCE_CYCLES=4): toggle key_raw[4] with high/low widths of 1–3 cycles for 40 cycles, then settle low → no apply_p; key_db[4] stays 0.
- Auto-repeat (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8): hold up for 60 cycles after debounce → up_p at t0, t0+20, t0+28, t0+36, t0+44, …; release → no further pulses, FSM returns to IDLE.
- Simultaneous press: key_raw[3] and key_raw[0] rise on the same edge and both hold → only up_p fires and repeats. Release up with right still held → no right_p. Release and re-press right → one right_p.
- Non-repeat hold: hold down... no; hold apply for 200 cycles with REPEAT_DELAY=20 → exactly one apply_p.
- Reset mid-repeat: assert _CR during the REPEAT state with down held → all outputs 0 immediately. Deassert with down still held → one down_p at DEBOUNCE_CYCLES+3 cycles after deassertion, then the repeat schedule restarts.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: raw push-button levels to clean one-cycle command pulses.
// Per-key sync + debounce, then a one-key-at-a-time press/auto-repeat FSM.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic       CP,
    input  logic       _CR,
    input  logic [4:0] key_raw,
    output logic       apply_p,
    output logic       up_p,
    output logic       down_p,
    output logic       left_p,
    output logic       right_p,
    output logic       busy,
    output logic [4:0] key_db
);

    localparam int DBW_RAW = $clog2(DEBOUNCE_CYCLES);
    localparam int DBW     = (DBW_RAW < 1) ? 1 : DBW_RAW;

    localparam int TMAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW_RAW = $clog2(TMAX);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    // Bit positions shared by key_raw, key_db and the pulse vector.
    localparam logic [4:0] K_APPLY = 5'b10000;
    localparam logic [4:0] K_UP    = 5'b01000;
    localparam logic [4:0] K_DOWN  = 5'b00100;
    localparam logic [4:0] K_LEFT  = 5'b00010;
    localparam logic [4:0] K_RIGHT = 5'b00001;
    localparam logic [4:0] K_REP   = K_UP | K_DOWN;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    key_db_prev;
    logic [4:0]    rise_q;
    logic [4:0]    pick;

    state_t        state;
    state_t        state_nx;
    logic [4:0]    cap;
    logic [4:0]    cap_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [4:0]    pulse_q;
    logic [4:0]    pulse_nx;
    logic          cap_held;
    logic          cap_rep;

    // Two-flop synchroniser for the asynchronous board pins.
    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_db
        logic [DBW-1:0] cnt;

        // Accept a new level only after DEBOUNCE_CYCLES stable mismatches.
        always_ff @(posedge CP or negedge _CR) begin
            if (!_CR) begin
                cnt       <= '0;
                key_db[g] <= 1'b0;
            end else if (sync2[g] == key_db[g]) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt       <= '0;
                key_db[g] <= sync2[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered rising-edge detect of the debounced levels.
    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            key_db_prev <= '0;
            rise_q      <= '0;
        end else begin
            key_db_prev <= key_db;
            rise_q      <= key_db & ~key_db_prev;
        end
    end

    // Fixed priority among simultaneous rises: apply > up > down > left > right.
    always_comb begin
        pick = '0;
        if (rise_q[4])
            pick = K_APPLY;
        else if (rise_q[3])
            pick = K_UP;
        else if (rise_q[2])
            pick = K_DOWN;
        else if (rise_q[1])
            pick = K_LEFT;
        else if (rise_q[0])
            pick = K_RIGHT;
    end

    assign cap_held = |(cap & key_db);
    assign cap_rep  = |(cap & K_REP);

    // Press FSM: capture one key, hold until release, auto-repeat up/down.
    always_comb begin
        state_nx = state;
        cap_nx   = cap;
        timer_nx = timer;
        pulse_nx = '0;
        case (state)
            IDLE: begin
                if (|rise_q) begin
                    pulse_nx = pick;
                    cap_nx   = pick;
                    timer_nx = '0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (!cap_held) begin
                    cap_nx   = '0;
                    state_nx = IDLE;
                end else if (cap_rep) begin
                    if (timer == DELAY_LAST) begin
                        pulse_nx = cap;
                        timer_nx = '0;
                        state_nx = REPEAT;
                    end else begin
                        timer_nx = timer + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!cap_held) begin
                    cap_nx   = '0;
                    state_nx = IDLE;
                end else if (timer == PERIOD_LAST) begin
                    pulse_nx = cap;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: begin
                cap_nx   = '0;
                timer_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, capture, timer, pulses and busy all register on the same edge.
    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            state   <= IDLE;
            cap     <= '0;
            timer   <= '0;
            pulse_q <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cap     <= cap_nx;
            timer   <= timer_nx;
            pulse_q <= pulse_nx;
            busy    <= (state_nx != IDLE);
        end
    end

    assign apply_p = pulse_q[4];
    assign up_p    = pulse_q[3];
    assign down_p  = pulse_q[2];
    assign left_p  = pulse_q[1];
    assign right_p = pulse_q[0];

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed steps with a pulse scoreboard.
// Expected pulse cycles are derived from the input drive times.
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       CP = 1'b0;
    logic       _CR = 1'b0;
    logic [4:0] key_raw = '0;
    logic       apply_p;
    logic       up_p;
    logic       down_p;
    logic       left_p;
    logic       right_p;
    logic       busy;
    logic [4:0] key_db;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CP(CP),
        ._CR(_CR),
        .key_raw(key_raw),
        .apply_p(apply_p),
        .up_p(up_p),
        .down_p(down_p),
        .left_p(left_p),
        .right_p(right_p),
        .busy(busy),
        .key_db(key_db)
    );

    always #5 CP = ~CP;

    typedef struct {
        int         cyc;
        logic [4:0] key;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [4:0] pv;

    assign pv = {apply_p, up_p, down_p, left_p, right_p};

    always @(posedge CP) cyc++;

    always @(negedge CP) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            tests++;
            assert (pv === e.key) else begin
                fails++;
                $error("FAIL pulse@%0d got %b want %b", cyc, pv, e.key);
            end
        end else if (pv !== 5'b0) begin
            tests++;
            assert (pv === 5'b0) else begin
                fails++;
                $error("FAIL stray@%0d got %b want 00000", cyc, pv);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s @%0d got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge CP);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CP);
    endtask

    // Pulses for a press first sampled at edge n, up to (excluding) stop.
    task automatic sched(input logic [4:0] k, input int n, input int stop,
                         input bit rep);
        int ec;
        bit first;
        ec = n + 3 + D;
        first = 1'b1;
        while (ec < stop) begin
            sb.push_back('{ec, k});
            if (!rep) break;
            ec += first ? RD : RP;
            first = 1'b0;
        end
    endtask

    initial begin
        int n;
        int r;
        int cr;

        repeat (3) @(negedge CP);
        chk("rst_pulse", pv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_db", key_db, 0);
        _CR = 1'b1;
        idle(5);

        // single left press, held 30 cycles
        n = cyc + 1;
        r = n + 30;
        sched(5'b00010, n, r + 2 + D, 1'b0);
        key_raw[1] = 1'b1;
        wait_to(n + D);
        chk("left_db_pre", key_db[1], 0);
        wait_to(n + 1 + D);
        chk("left_db_on", key_db[1], 1);
        wait_to(n + 2 + D);
        chk("left_busy_pre", busy, 0);
        wait_to(n + 3 + D);
        chk("left_busy_on", busy, 1);
        wait_to(r - 1);
        key_raw[1] = 1'b0;
        wait_to(r + D);
        chk("left_db_hold", key_db[1], 1);
        wait_to(r + 1 + D);
        chk("left_db_off", key_db[1], 0);
        chk("left_busy_tail", busy, 1);
        wait_to(r + 2 + D);
        chk("left_busy_off", busy, 0);
        idle(10);

        // bouncing apply, pulses of 1..3 cycles
        for (int i = 0; i < 40;) begin
            int w;
            w = $urandom_range(1, 3);
            key_raw[4] = ~key_raw[4];
            repeat (w) begin
                @(negedge CP);
                chk("bounce_db", key_db[4], 0);
                i++;
            end
        end
        key_raw[4] = 1'b0;
        idle(D + 6);
        chk("bounce_db_end", key_db, 0);
        chk("bounce_busy", busy, 0);

        // up auto-repeat, released 60 cycles after debounce
        n = cyc + 1;
        r = n + 1 + D + 60;
        sched(5'b01000, n, r + 2 + D, 1'b1);
        key_raw[3] = 1'b1;
        wait_to(r - 1);
        key_raw[3] = 1'b0;
        wait_to(r + 1 + D);
        chk("up_busy_tail", busy, 1);
        wait_to(r + 2 + D);
        chk("up_busy_off", busy, 0);
        idle(10);

        // up and right together: up wins, right discarded
        n = cyc + 1;
        r = n + 40;
        sched(5'b01000, n, r + 2 + D, 1'b1);
        key_raw[3] = 1'b1;
        key_raw[0] = 1'b1;
        wait_to(r - 1);
        key_raw[3] = 1'b0;
        wait_to(r + 3 + D);
        chk("sim_busy_off", busy, 0);
        chk("sim_right_db", key_db, 5'b00001);
        idle(15);
        key_raw[0] = 1'b0;
        idle(D + 6);
        n = cyc + 1;
        r = n + 15;
        sched(5'b00001, n, r + 2 + D, 1'b0);
        key_raw[0] = 1'b1;
        wait_to(r - 1);
        key_raw[0] = 1'b0;
        idle(D + 8);

        // apply held 200 cycles fires once
        n = cyc + 1;
        r = n + 200;
        sched(5'b10000, n, r + 2 + D, 1'b0);
        key_raw[4] = 1'b1;
        wait_to(n + 100);
        chk("apply_busy_mid", busy, 1);
        wait_to(r - 1);
        key_raw[4] = 1'b0;
        idle(D + 8);
        chk("apply_busy_off", busy, 0);

        // reset in the middle of a down repeat
        n = cyc + 1;
        cr = n + 3 + D + RD + 3;
        sched(5'b00100, n, cr + 1, 1'b1);
        key_raw[2] = 1'b1;
        wait_to(cr);
        _CR = 1'b0;
        #1;
        chk("rst_mid_pulse", pv, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_db", key_db, 0);
        wait_to(cr + 3);
        chk("rst_mid_hold", {busy, key_db}, 0);
        n = cyc + 1;
        r = n + 40;
        sched(5'b00100, n, r + 2 + D, 1'b1);
        _CR = 1'b1;
        wait_to(r - 1);
        key_raw[2] = 1'b0;
        idle(D + 8);
        chk("down_busy_off", busy, 0);

        idle(20);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
